// File: rtl/hazard_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : hazard_ctrl_if
// Description : Pipeline-to-hazard-unit signal bundle (stage operands, stall,
//               forwarding selects and mult/div status).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_ctrl_if;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic        d_is_md;
    logic [4:0]  e_a3;
    logic [4:0]  m_a3;
    logic [1:0]  e_tnew;
    logic [1:0]  m_tnew;
    logic        e_md_start;
    logic        e_md_div;
    logic        stall;
    logic        pc_en;
    logic        fd_en;
    logic        de_flush;
    logic [1:0]  fw_rs_sel;
    logic [1:0]  fw_rt_sel;
    logic        md_busy;
    logic [3:0]  md_count;
    logic [15:0] stall_cycles;

    modport master (
        output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        output e_a3, m_a3, e_tnew, m_tnew, e_md_start, e_md_div,
        input  stall, pc_en, fd_en, de_flush, fw_rs_sel, fw_rt_sel,
        input  md_busy, md_count, stall_cycles
    );

    modport slave (
        input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
        input  e_a3, m_a3, e_tnew, m_tnew, e_md_start, e_md_div,
        output stall, pc_en, fd_en, de_flush, fw_rs_sel, fw_rt_sel,
        output md_busy, md_count, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : hazard_ctrl
// Description : Tuse/Tnew stall and forwarding control with mult/div busy
//               counter and a saturating stall statistic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_ctrl (
    input  wire logic   clk,
    input  wire logic   reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [3:0]  C_MULT_CYCLES = 4'd5;
    localparam logic [3:0]  C_DIV_CYCLES  = 4'd10;
    localparam logic [15:0] C_STALL_MAX   = 16'hFFFF;

    logic [3:0]  r_md_count;
    logic [15:0] r_stall_cycles;

    logic w_md_busy;
    logic w_stall_rs;
    logic w_stall_rt;
    logic w_md_stall;
    logic w_stall;

    assign w_md_busy = (r_md_count != 4'd0);

    // A producer stalls the consumer only if its result arrives later than needed.
    assign w_stall_rs = (hz.d_rs != 5'd0) &&
                        (((hz.e_a3 == hz.d_rs) && (hz.e_tnew > hz.d_tuse_rs)) ||
                         ((hz.m_a3 == hz.d_rs) && (hz.m_tnew > hz.d_tuse_rs)));
    assign w_stall_rt = (hz.d_rt != 5'd0) &&
                        (((hz.e_a3 == hz.d_rt) && (hz.e_tnew > hz.d_tuse_rt)) ||
                         ((hz.m_a3 == hz.d_rt) && (hz.m_tnew > hz.d_tuse_rt)));
    assign w_md_stall = hz.d_is_md && (w_md_busy || hz.e_md_start);
    assign w_stall    = w_stall_rs || w_stall_rt || w_md_stall;

    always_comb begin
        hz.fw_rs_sel = 2'd0;
        if ((hz.d_rs != 5'd0) && (hz.e_a3 == hz.d_rs) && (hz.e_tnew == 2'd0))
            hz.fw_rs_sel = 2'd2;
        else if ((hz.d_rs != 5'd0) && (hz.m_a3 == hz.d_rs) && (hz.m_tnew == 2'd0))
            hz.fw_rs_sel = 2'd1;
    end

    always_comb begin
        hz.fw_rt_sel = 2'd0;
        if ((hz.d_rt != 5'd0) && (hz.e_a3 == hz.d_rt) && (hz.e_tnew == 2'd0))
            hz.fw_rt_sel = 2'd2;
        else if ((hz.d_rt != 5'd0) && (hz.m_a3 == hz.d_rt) && (hz.m_tnew == 2'd0))
            hz.fw_rt_sel = 2'd1;
    end

    // New issues are accepted only when idle; a start while busy is dropped.
    always_ff @(posedge clk) begin
        if (reset)
            r_md_count <= 4'd0;
        else if (hz.e_md_start && !w_md_busy)
            r_md_count <= hz.e_md_div ? C_DIV_CYCLES : C_MULT_CYCLES;
        else if (w_md_busy)
            r_md_count <= r_md_count - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cycles <= 16'd0;
        else if (w_stall && (r_stall_cycles != C_STALL_MAX))
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign hz.stall        = w_stall;
    assign hz.pc_en        = !w_stall;
    assign hz.fd_en        = !w_stall;
    assign hz.de_flush     = w_stall;
    assign hz.md_busy      = w_md_busy;
    assign hz.md_count     = r_md_count;
    assign hz.stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios plus
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model state: plain integers for remaining md cycles and stalls.
    int   mdl_md;
    int   mdl_sc;

    hazard_ctrl_if hif ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit src_stall(input int r, input int tuse);
        if (r == 0) return 1'b0;
        if ((int'(hif.e_a3) == r) && (int'(hif.e_tnew) > tuse)) return 1'b1;
        if ((int'(hif.m_a3) == r) && (int'(hif.m_tnew) > tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        bit md;
        md = hif.d_is_md && ((mdl_md > 0) || hif.e_md_start);
        return src_stall(int'(hif.d_rs), int'(hif.d_tuse_rs)) ||
               src_stall(int'(hif.d_rt), int'(hif.d_tuse_rt)) || md;
    endfunction

    function automatic logic [1:0] exp_fw(input int r);
        if (r == 0) return 2'd0;
        if ((int'(hif.e_a3) == r) && (hif.e_tnew == 2'd0)) return 2'd2;
        if ((int'(hif.m_a3) == r) && (hif.m_tnew == 2'd0)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic idle_inputs();
        hif.d_rs = 5'd0;  hif.d_rt = 5'd0;
        hif.d_tuse_rs = 2'd3; hif.d_tuse_rt = 2'd3;
        hif.d_is_md = 1'b0;
        hif.e_a3 = 5'd0;  hif.m_a3 = 5'd0;
        hif.e_tnew = 2'd0; hif.m_tnew = 2'd0;
        hif.e_md_start = 1'b0; hif.e_md_div = 1'b0;
    endtask

    // Advance one rising edge, stepping the model with the inputs seen there.
    task automatic tick();
        bit st;
        @(posedge clk);
        st = exp_stall();
        if (reset) begin
            mdl_md = 0;
            mdl_sc = 0;
        end else begin
            if (st && mdl_sc < 65535) mdl_sc = mdl_sc + 1;
            if (hif.e_md_start && mdl_md == 0) mdl_md = hif.e_md_div ? 10 : 5;
            else if (mdl_md > 0) mdl_md = mdl_md - 1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (hif.md_count !== 4'd0 || hif.md_busy !== 1'b0 || hif.stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: md_count=%0d md_busy=%0b stall_cycles=%0d, required 0/0/0",
                     hif.md_count, hif.md_busy, hif.stall_cycles);
        end
        checks++;
        if (hif.stall !== 1'b0 || hif.pc_en !== 1'b1 || hif.fw_rs_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_comb: stall=%0b pc_en=%0b fw_rs=%0d, required 0/1/0",
                     hif.stall, hif.pc_en, hif.fw_rs_sel);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        hif.e_a3 = 5'd5; hif.e_tnew = 2'd2; hif.d_rs = 5'd5; hif.d_tuse_rs = 2'd1;
        #1;
        checks++;
        if (hif.stall !== 1'b1 || hif.pc_en !== 1'b0 || hif.fd_en !== 1'b0 || hif.de_flush !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: stall=%0b pc_en=%0b fd_en=%0b de_flush=%0b, required 1/0/0/1",
                     hif.stall, hif.pc_en, hif.fd_en, hif.de_flush);
        end
        tick();
        checks++;
        if (hif.stall_cycles !== 16'd1) begin
            errors++;
            $display("FAIL load_use_count: stall_cycles=%0d, required 1", hif.stall_cycles);
        end
        @(negedge clk);
        hif.e_tnew = 2'd0;
        #1;
        checks++;
        if (hif.stall !== 1'b0 || hif.fw_rs_sel !== 2'd2) begin
            errors++;
            $display("FAIL load_use_fwd: stall=%0b fw_rs_sel=%0d, required 0/2", hif.stall, hif.fw_rs_sel);
        end
    endtask

    task automatic test_double_hit();
        do_reset();
        hif.e_a3 = 5'd7; hif.m_a3 = 5'd7; hif.e_tnew = 2'd0; hif.m_tnew = 2'd0;
        hif.d_rt = 5'd7; hif.d_tuse_rt = 2'd0;
        #1;
        checks++;
        if (hif.fw_rt_sel !== 2'd2) begin
            errors++;
            $display("FAIL double_hit_e: fw_rt_sel=%0d, required 2", hif.fw_rt_sel);
        end
        hif.e_a3 = 5'd0;
        #1;
        checks++;
        if (hif.fw_rt_sel !== 2'd1) begin
            errors++;
            $display("FAIL double_hit_m: fw_rt_sel=%0d, required 1", hif.fw_rt_sel);
        end
        // Register 0 must never forward or stall, even with a late producer.
        hif.d_rt = 5'd0; hif.e_a3 = 5'd0; hif.m_a3 = 5'd0; hif.m_tnew = 2'd3;
        #1;
        checks++;
        if (hif.fw_rt_sel !== 2'd0 || hif.stall !== 1'b0) begin
            errors++;
            $display("FAIL reg_zero: fw_rt_sel=%0d stall=%0b, required 0/0", hif.fw_rt_sel, hif.stall);
        end
    endtask

    task automatic test_div();
        do_reset();
        hif.d_is_md = 1'b1; hif.e_md_start = 1'b1; hif.e_md_div = 1'b1;
        #1;
        checks++;
        if (hif.stall !== 1'b1) begin
            errors++;
            $display("FAIL div_issue_stall: stall=%0b, required 1", hif.stall);
        end
        tick();
        checks++;
        if (hif.md_count !== 4'd10) begin
            errors++;
            $display("FAIL div_load: md_count=%0d, required 10", hif.md_count);
        end
        for (int k = 9; k >= 0; k--) begin
            @(negedge clk);
            hif.e_md_start = (k == 3);
            #1;
            checks++;
            if (hif.stall !== 1'b1) begin
                errors++;
                $display("FAIL div_busy_stall: k=%0d stall=%0b, required 1", k, hif.stall);
            end
            tick();
            checks++;
            if (hif.md_count !== 4'(k)) begin
                errors++;
                $display("FAIL div_count: md_count=%0d, required %0d", hif.md_count, k);
            end
        end
        @(negedge clk);
        hif.e_md_start = 1'b0;
        #1;
        checks++;
        if (hif.stall !== 1'b0 || hif.md_busy !== 1'b0) begin
            errors++;
            $display("FAIL div_done: stall=%0b md_busy=%0b, required 0/0", hif.stall, hif.md_busy);
        end
    endtask

    task automatic test_mult_reset();
        do_reset();
        hif.e_md_start = 1'b1; hif.e_md_div = 1'b0;
        tick();
        checks++;
        if (hif.md_count !== 4'd5) begin
            errors++;
            $display("FAIL mult_load: md_count=%0d, required 5", hif.md_count);
        end
        @(negedge clk);
        hif.e_md_start = 1'b0;
        hif.d_is_md = 1'b1;
        tick();
        tick();
        checks++;
        if (hif.md_count !== 4'd3) begin
            errors++;
            $display("FAIL mult_count3: md_count=%0d, required 3", hif.md_count);
        end
        // Reset must win over a new issue and over stall counting.
        @(negedge clk);
        reset = 1'b1;
        hif.e_md_start = 1'b1;
        tick();
        checks++;
        if (hif.md_count !== 4'd0 || hif.md_busy !== 1'b0 || hif.stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL mult_reset: md_count=%0d md_busy=%0b stall_cycles=%0d, required 0/0/0",
                     hif.md_count, hif.md_busy, hif.stall_cycles);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [1:0] e_rs, e_rt;
        logic       e_st;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            reset          = ($urandom_range(0, 79) == 0);
            hif.d_rs       = 5'($urandom_range(0, 3));
            hif.d_rt       = 5'($urandom_range(0, 3));
            hif.d_tuse_rs  = 2'($urandom_range(0, 3));
            hif.d_tuse_rt  = 2'($urandom_range(0, 3));
            hif.d_is_md    = ($urandom_range(0, 2) == 0);
            hif.e_a3       = 5'($urandom_range(0, 3));
            hif.m_a3       = 5'($urandom_range(0, 3));
            hif.e_tnew     = 2'($urandom_range(0, 3));
            hif.m_tnew     = 2'($urandom_range(0, 3));
            hif.e_md_start = ($urandom_range(0, 7) == 0);
            hif.e_md_div   = 1'($urandom_range(0, 1));
            #1;
            e_st = exp_stall();
            e_rs = exp_fw(int'(hif.d_rs));
            e_rt = exp_fw(int'(hif.d_rt));
            checks++;
            if (hif.stall !== e_st || hif.pc_en !== !e_st || hif.fd_en !== !e_st || hif.de_flush !== e_st) begin
                errors++;
                $display("FAIL rand_stall: n=%0d stall=%0b pc_en=%0b fd_en=%0b de_flush=%0b, required stall=%0b",
                         n, hif.stall, hif.pc_en, hif.fd_en, hif.de_flush, e_st);
            end
            checks++;
            if (hif.fw_rs_sel !== e_rs || hif.fw_rt_sel !== e_rt) begin
                errors++;
                $display("FAIL rand_fwd: n=%0d fw_rs=%0d fw_rt=%0d, required %0d/%0d",
                         n, hif.fw_rs_sel, hif.fw_rt_sel, e_rs, e_rt);
            end
            tick();
            checks++;
            if (int'(hif.md_count) != mdl_md || hif.md_busy !== (mdl_md != 0) || int'(hif.stall_cycles) != mdl_sc) begin
                errors++;
                $display("FAIL rand_state: n=%0d md_count=%0d md_busy=%0b stall_cycles=%0d, required %0d/%0b/%0d",
                         n, hif.md_count, hif.md_busy, hif.stall_cycles, mdl_md, (mdl_md != 0), mdl_sc);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        hif.d_is_md = 1'b1;
        hif.e_md_start = 1'b1;
        #1;
        checks++;
        if (hif.stall !== 1'b1) begin
            errors++;
            $display("FAIL sat_issue_stall: stall=%0b, required 1", hif.stall);
        end
        for (int n = 1; n <= 65540; n++) begin
            tick();
            if (n == 65534) begin
                checks++;
                if (hif.stall_cycles !== 16'hFFFE) begin
                    errors++;
                    $display("FAIL sat_before: stall_cycles=%0h, required fffe", hif.stall_cycles);
                end
            end
        end
        checks++;
        if (hif.stall_cycles !== 16'hFFFF || int'(hif.stall_cycles) != mdl_sc) begin
            errors++;
            $display("FAIL sat_hold: stall_cycles=%0h, required ffff", hif.stall_cycles);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mdl_md = 0;
        mdl_sc = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_double_hit();
        test_div();
        test_mult_reset();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
